// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM for the multicycle RV32I core. Each instruction passes
// through fetch, decode and then a short opcode-specific sequence (memory
// access, ALU execute, branch resolution, jump handling), and then returns to
// fetch. The FSM drives the datapath enables and mux selects. It also produces
// the ALU operation class for the ALU decoder that sits downstream.
//
// Ports
//   i_clk        : clock, rising edge
//   i_rst        : synchronous active-high reset
//   i_opecode    : opcode field of the instruction register
//   i_funct3     : funct3 field of the instruction register
//   i_zero       : ALU result == 0
//   i_lt         : signed rs1 < rs2
//   i_ltu        : unsigned rs1 < rs2
//   i_mem_ready  : memory completes the current request this cycle
//   o_MemReq     : memory access requested
//   o_MemWrite   : the access is a write
//   o_IRWrite    : load instruction register and OldPC
//   o_PCWrite    : load PC from Result
//   o_RegWrite   : register file write
//   o_AdrSrc     : memory address, 0 = PC, 1 = Result
//   o_ALUSrcA    : 00 PC, 01 OldPC, 10 rs1, 11 zero
//   o_ALUSrcB    : 00 rs2, 01 immediate, 10 constant 4
//   o_ResultSrc  : 00 ALUOut, 01 read data, 10 ALU result
//   o_ImmSrc     : 000 I, 001 S, 010 B, 011 J, 100 U
//   o_ALUOp      : 00 add, 01 subtract/compare, 10 decode from funct
//   o_illegal    : one-cycle pulse on an unsupported encoding
//   o_state      : current state (debug)
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_opecode,
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_lt,
  input  logic       i_ltu,
  input  logic       i_mem_ready,
  output logic       o_MemReq,
  output logic       o_MemWrite,
  output logic       o_IRWrite,
  output logic       o_PCWrite,
  output logic       o_RegWrite,
  output logic       o_AdrSrc,
  output logic [1:0] o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic [1:0] o_ResultSrc,
  output logic [2:0] o_ImmSrc,
  output logic [1:0] o_ALUOp,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  // Opcodes of the supported RV32I instruction classes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Mux select encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Branch condition decode from funct3. Encodings 010 and 011 are not
  // branches, so they are never taken and are flagged as illegal.
  logic branch_taken;
  logic branch_bad;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Immediate format depends only on the opcode
  // ---------------------------------------------------------------------------
  always_comb begin
    o_ImmSrc = IMM_I;
    case (i_opecode)
      OP_STORE:         o_ImmSrc = IMM_S;
      OP_BRANCH:        o_ImmSrc = IMM_B;
      OP_JAL:           o_ImmSrc = IMM_J;
      OP_LUI, OP_AUIPC: o_ImmSrc = IMM_U;
      default:          o_ImmSrc = IMM_I;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    branch_bad   = 1'b0;
    case (i_funct3)
      3'b000:  branch_taken = i_zero;
      3'b001:  branch_taken = ~i_zero;
      3'b100:  branch_taken = i_lt;
      3'b101:  branch_taken = ~i_lt;
      3'b110:  branch_taken = i_ltu;
      3'b111:  branch_taken = ~i_ltu;
      default: branch_bad   = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    o_MemReq    = 1'b0;
    o_MemWrite  = 1'b0;
    o_IRWrite   = 1'b0;
    o_PCWrite   = 1'b0;
    o_RegWrite  = 1'b0;
    o_AdrSrc    = 1'b0;
    o_ALUSrcA   = SRCA_PC;
    o_ALUSrcB   = SRCB_RS2;
    o_ResultSrc = RES_ALUOUT;
    o_ALUOp     = ALUOP_ADD;
    o_illegal   = 1'b0;

    case (state_reg)
      S_FETCH: begin
        // PC+4 flows straight through the ALU into PC. The IR and PC are only
        // loaded in the cycle the memory returns the instruction.
        o_MemReq    = 1'b1;
        o_ALUSrcA   = SRCA_PC;
        o_ALUSrcB   = SRCB_FOUR;
        o_ResultSrc = RES_ALU;
        o_IRWrite   = i_mem_ready;
        o_PCWrite   = i_mem_ready;
        if (i_mem_ready) begin
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch/jal target OldPC+imm is precomputed into ALUOut here
        o_ALUSrcA = SRCA_OLDPC;
        o_ALUSrcB = SRCB_IMM;
        case (i_opecode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          default: begin
            o_illegal  = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        o_ALUSrcA = SRCA_RS1;
        o_ALUSrcB = SRCB_IMM;
        // Load and store opcodes differ only in bit 5
        state_next = i_opecode[5] ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        o_MemReq    = 1'b1;
        o_AdrSrc    = 1'b1;
        o_ResultSrc = RES_ALUOUT;
        if (i_mem_ready) begin
          state_next = S_MEMWB;
        end
      end

      S_MEMWB: begin
        o_ResultSrc = RES_RDATA;
        o_RegWrite  = 1'b1;
        state_next  = S_FETCH;
      end

      S_MEMWRITE: begin
        o_MemReq    = 1'b1;
        o_MemWrite  = 1'b1;
        o_AdrSrc    = 1'b1;
        o_ResultSrc = RES_ALUOUT;
        if (i_mem_ready) begin
          state_next = S_FETCH;
        end
      end

      S_EXECR: begin
        o_ALUSrcA  = SRCA_RS1;
        o_ALUSrcB  = SRCB_RS2;
        o_ALUOp    = ALUOP_FUNC;
        state_next = S_ALUWB;
      end

      S_EXECI: begin
        o_ALUSrcA  = SRCA_RS1;
        o_ALUSrcB  = SRCB_IMM;
        o_ALUOp    = ALUOP_FUNC;
        state_next = S_ALUWB;
      end

      S_ALUWB: begin
        o_ResultSrc = RES_ALUOUT;
        o_RegWrite  = 1'b1;
        state_next  = S_FETCH;
      end

      S_BRANCH: begin
        // ALU compares rs1/rs2 while ALUOut still holds the target from
        // DECODE, so a taken branch loads PC from ALUOut.
        o_ALUSrcA   = SRCA_RS1;
        o_ALUSrcB   = SRCB_RS2;
        o_ALUOp     = ALUOP_SUB;
        o_ResultSrc = RES_ALUOUT;
        o_PCWrite   = branch_taken;
        o_illegal   = branch_bad;
        state_next  = S_FETCH;
      end

      S_JAL: begin
        // PC takes the target in ALUOut while the ALU forms OldPC+4 for
        // the link value written back in ALUWB.
        o_ALUSrcA   = SRCA_OLDPC;
        o_ALUSrcB   = SRCB_FOUR;
        o_ALUOp     = ALUOP_ADD;
        o_ResultSrc = RES_ALUOUT;
        o_PCWrite   = 1'b1;
        state_next  = S_ALUWB;
      end

      S_JALR: begin
        // Replaces the DECODE target with rs1+imm, then shares the JAL path.
        // The datapath clears bit 0 of the target.
        o_ALUSrcA  = SRCA_RS1;
        o_ALUSrcB  = SRCB_IMM;
        state_next = S_JAL;
      end

      S_LUI: begin
        o_ALUSrcA  = SRCA_ZERO;
        o_ALUSrcB  = SRCB_IMM;
        state_next = S_ALUWB;
      end

      S_AUIPC: begin
        o_ALUSrcA  = SRCA_OLDPC;
        o_ALUSrcB  = SRCB_IMM;
        state_next = S_ALUWB;
      end

      default: begin
        state_next = S_FETCH;
      end
    endcase

    // Reset overrides everything. Enables are quiet, and the selects show
    // their fetch values so that the first post-reset cycle looks like a
    // clean fetch.
    if (i_rst) begin
      o_MemReq    = 1'b0;
      o_MemWrite  = 1'b0;
      o_IRWrite   = 1'b0;
      o_PCWrite   = 1'b0;
      o_RegWrite  = 1'b0;
      o_illegal   = 1'b0;
      o_AdrSrc    = 1'b0;
      o_ALUSrcA   = SRCA_PC;
      o_ALUSrcB   = SRCB_FOUR;
      o_ResultSrc = RES_ALU;
      o_ALUOp     = ALUOP_ADD;
    end
  end

  assign o_state = i_rst ? 4'd0 : state_reg;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the datapath enables and mux selects, and produces `o_ALUOp` for the ALU decoder that sits directly downstream. Branch resolution uses the ALU compare flags, and a memory-ready handshake stalls fetch and data access.

## Interface
- No parameters.
- `i_clk` in 1: clock; all state changes on the rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_opecode` in 7: opcode field from the instruction register.
- `i_funct3` in 3: funct3 field from the instruction register.
- `i_zero` in 1: ALU result == 0.
- `i_lt` in 1: signed rs1 < rs2.
- `i_ltu` in 1: unsigned rs1 < rs2.
- `i_mem_ready` in 1: memory completes the current request this cycle.
- `o_MemReq` out 1: memory access requested.
- `o_MemWrite` out 1: the access is a write.
- `o_IRWrite` out 1: load the instruction register and OldPC.
- `o_PCWrite` out 1: load PC from Result.
- `o_RegWrite` out 1: register file write.
- `o_AdrSrc` out 1: memory address select; 0 = PC, 1 = Result.
- `o_ALUSrcA` out 2: ALU operand A select; 00 = PC, 01 = OldPC, 10 = rs1 data, 11 = zero.
- `o_ALUSrcB` out 2: ALU operand B select; 00 = rs2 data, 01 = immediate, 10 = constant 4.
- `o_ResultSrc` out 2: Result select; 00 = ALUOut register, 01 = read-data register, 10 = ALU result.
- `o_ImmSrc` out 3: immediate format; 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `o_ALUOp` out 2: ALU operation class; 00 = add, 01 = subtract/compare, 10 = decode from funct.
- `o_illegal` out 1: one-cycle pulse when an unsupported encoding is detected.
- `o_state` out 4: current state, for debug.

## Operation
- `o_ImmSrc` is combinational from `i_opecode`. Mapping: store → S; branch → B; jal → J; lui/auipc → U; all other opcodes → I.
- Outputs are Moore per state. The exceptions are the handshake-gated enables and the branch-gated `o_PCWrite`. Any output not listed for a state is 0 (selects 00).
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE, 6 EXECR, 7 EXECI, 8 ALUWB, 9 BRANCH, 10 JAL, 11 JALR, 12 LUI, 13 AUIPC.
- FETCH:
  - Outputs: MemReq=1, AdrSrc=0, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCWrite equal `i_mem_ready`.
  - Stays in FETCH until `i_mem_ready`, then → DECODE.
- DECODE: SrcA=01, SrcB=01, ALUOp=00 (computes the branch/jal target). Next state by opcode:
  - 0000011 and 0100011 → MEMADR.
  - 0110011 → EXECR; 0010011 → EXECI.
  - 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR.
  - 0110111 → LUI; 0010111 → AUIPC.
  - Any other opcode: `o_illegal`=1 for one cycle → FETCH.
- MEMADR: SrcA=10, SrcB=01, ALUOp=00. Goes to MEMWRITE if `i_opecode[5]`, else MEMREAD.
- MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00. Holds until `i_mem_ready`, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1, ResultSrc=00. Holds until `i_mem_ready`, then → FETCH.
- EXECR: SrcA=10, SrcB=00, ALUOp=10 → ALUWB.
- EXECI: SrcA=10, SrcB=01, ALUOp=10 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BRANCH: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00. Then → FETCH.
  - `o_PCWrite` = taken, decoded from funct3: 000 `zero`, 001 `!zero`, 100 `lt`, 101 `!lt`, 110 `ltu`, 111 `!ltu`.
  - funct3 010 or 011: not taken and `o_illegal`=1.
- JAL: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 → ALUWB. ALUWB then writes OldPC+4.
- JALR: SrcA=10, SrcB=01, ALUOp=00 → JAL. ALUOut now holds rs1+imm; clearing bit 0 is done in the datapath.
- LUI: SrcA=11, SrcB=01, ALUOp=00 → ALUWB.
- AUIPC: SrcA=01, SrcB=01, ALUOp=00 → ALUWB.

## Timing
- `i_rst`=1 at a clock edge → next state FETCH.
- While `i_rst`=1:
  - MemReq, MemWrite, IRWrite, PCWrite, RegWrite and `o_illegal` are forced to 0.
  - Selects show FETCH values: AdrSrc=0, SrcA=00, SrcB=10, ResultSrc=10, ALUOp=00.
  - `o_state`=0.
- Reset has priority over any state, including mid-stall in MEMREAD/MEMWRITE.
- Cycle counts with `i_mem_ready` constantly 1:

  | Instruction | Cycles |
  |---|---|
  | R, I-ALU, store, jal, lui, auipc | 4 |
  | load, jalr | 5 |
  | branch | 3 |

- Each cycle with `i_mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. During the stall all outputs hold steady and no enable other than MemReq/MemWrite is asserted.
- `i_zero`, `i_lt`, `i_ltu` are sampled only in BRANCH. `i_opecode` and `i_funct3` are assumed stable from DECODE until the next FETCH.

## Test plan
- Reset: hold `i_rst`=1 for 3 cycles → `o_state`=0, all enables 0. Release with ready=1 → IRWrite=PCWrite=1 in the first cycle, `o_state`=1 next cycle.
- add (0110011), ready=1 → states 0,1,6,8,0.
  - EXECR: ALUOp=10, SrcB=00.
  - ALUWB: RegWrite=1, ResultSrc=00.
- lw (0000011) with ready low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0. AdrSrc=1 held throughout MEMREAD; RegWrite=1 only in MEMWB with ResultSrc=01.
- Branches:
  - bne (funct3 001) with `i_zero`=0 → PCWrite=1 in BRANCH.
  - beq (funct3 000) with `i_zero`=0 → PCWrite=0.
  - blt (funct3 100) with `i_lt`=1 → PCWrite=1.
  - bgeu (funct3 111) with `i_ltu`=1 → PCWrite=0.
  - funct3 010 → `o_illegal` pulse.
- Jumps:
  - jalr (1100111) → states 0,1,11,10,8,0; PCWrite=1 in JAL, RegWrite=1 in ALUWB.
  - lui (0110111) → SrcA=11, ImmSrc=100.
- Illegal opcode 1111111 → `o_illegal`=1 in DECODE only, next state FETCH. Asserting `i_rst` during MEMWRITE stall → FETCH next cycle, MemWrite=0.
